// File: rtl/bus_stream_fifo_pkg.sv
// Shared constants and types for the bus-to-stream FIFO slave.
// Address map, register selectors and STATUS bit positions.
package bus_stream_fifo_pkg;

    localparam logic [15:0] BUS_FIFO_OFFSET = 16'h0040;
    localparam int          BUS_FIFO_SIZE   = 4;

    typedef enum logic [1:0] {
        REG_DATA      = 2'd0,
        REG_STATUS    = 2'd1,
        REG_CONTROL   = 2'd2,
        REG_WATERMARK = 2'd3
    } reg_addr_e;

    localparam int STAT_OVF_BIT   = 15;
    localparam int STAT_FULL_BIT  = 14;
    localparam int STAT_EMPTY_BIT = 13;

    localparam int CTRL_FLUSH_BIT   = 0;
    localparam int CTRL_CLR_OVF_BIT = 1;

endpackage

// File: rtl/sync_fifo_core.sv
// Register-array FIFO with push, pop and flush; flush wins over both.
// Count is one bit wider than the pointers so full and empty are distinct.
module sync_fifo_core
    import bus_stream_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int WORD_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WORD_WIDTH-1:0] push_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic [WORD_WIDTH-1:0] head,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  push_drop
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WORD_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // A full FIFO still accepts a push when a pop frees a slot the same cycle
    assign do_pop    = pop & ~empty & ~flush;
    assign do_push   = push & (~full | do_pop) & ~flush;
    assign push_drop = push & ~flush & full & ~do_pop;

    // Storage write; contents need no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_stream_fifo.sv
// Bus slave feeding a valid/ready stream through a small FIFO.
// Optional watermark register and level_irq under BUS_FIFO_WATERMARK_EN.
module bus_stream_fifo
    import bus_stream_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int WORD_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  select,
    input  logic                  direct_in,
    input  logic [1:0]            addr_in,
    input  logic [WORD_WIDTH-1:0] data_in,
    input  logic                  data_strobe,
    output logic [WORD_WIDTH-1:0] data_out,
    output logic                  error,
    output logic                  m_valid,
    output logic [WORD_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  level_irq
);

    reg_addr_e             reg_sel;
    logic                  wr_stb;
    logic                  rd_stb;
    logic                  push;
    logic                  flush;
    logic                  clr_ovf;
    logic                  bad_access;
    logic                  overflow;
    logic [WORD_WIDTH-1:0] head;
    logic [DEPTH_LOG2:0]   count;
    logic                  full;
    logic                  empty;
    logic                  push_drop;
    logic [WORD_WIDTH-1:0] status;
    logic [DEPTH_LOG2:0]   watermark;

    assign reg_sel = reg_addr_e'(addr_in);
    assign wr_stb  = select & direct_in & data_strobe;
    assign rd_stb  = select & ~direct_in & data_strobe;

    assign push    = wr_stb & (reg_sel == REG_DATA);
    assign flush   = wr_stb & (reg_sel == REG_CONTROL)
                   & data_in[CTRL_FLUSH_BIT];
    assign clr_ovf = wr_stb & (reg_sel == REG_CONTROL)
                   & data_in[CTRL_CLR_OVF_BIT];

    assign bad_access = (wr_stb & (reg_sel == REG_STATUS))
                      | (rd_stb & (reg_sel == REG_CONTROL));

    assign m_valid = ~empty;
    assign m_data  = head;

    sync_fifo_core #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (data_in),
        .pop       (m_ready),
        .flush     (flush),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .push_drop (push_drop)
    );

    // Sticky overflow flag and one-cycle error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            error    <= 1'b0;
        end else begin
            if (clr_ovf) begin
                overflow <= 1'b0;
            end else if (push_drop) begin
                overflow <= 1'b1;
            end
            error <= bad_access | push_drop;
        end
    end

`ifdef BUS_FIFO_WATERMARK_EN
    // Watermark register and registered level comparison
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            watermark <= '0;
            level_irq <= 1'b0;
        end else begin
            if (wr_stb && reg_sel == REG_WATERMARK) begin
                watermark <= data_in[DEPTH_LOG2:0];
            end
            level_irq <= (watermark != '0) && (count >= watermark);
        end
    end
`else
    assign watermark = '0;
    assign level_irq = 1'b0;
`endif

    // Assemble the STATUS word
    always_comb begin
        status = '0;
        status[STAT_OVF_BIT]   = overflow;
        status[STAT_FULL_BIT]  = full;
        status[STAT_EMPTY_BIT] = empty;
        status[DEPTH_LOG2:0]   = count;
    end

    // Combinational read mux, valid ahead of the strobe
    always_comb begin
        data_out = '0;
        if (select && !direct_in) begin
            unique case (reg_sel)
                REG_DATA:      data_out = empty ? '0 : head;
                REG_STATUS:    data_out = status;
                REG_CONTROL:   data_out = '0;
                REG_WATERMARK: data_out = WORD_WIDTH'(watermark);
                default:       data_out = '0;
            endcase
        end
    end

endmodule
